display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter HOLD_MIN, default 100000000, minimum cycles an owner keeps the display once granted (legal range 1..2^32-1).
REQ-002 SHALL have parameter MAX_HOLD, default 500000000, cycles after which a still-requesting owner is preempted (only with DISP_SCHED_TIMEOUT_EN; SHALL be >= HOLD_MIN).
REQ-003 SHALL have port clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  3  req[i] high = requester i wants the display.
REQ-006 SHALL have port value0/value1/value2  input  16 each  requester i hex value; [15:12] leftmost digit.
REQ-007 SHALL have port grant  output  3  one-hot owner indication; all zero when no owner.
REQ-008 SHALL have port owner  output  2  index of current owner; 2'd3 when none.
REQ-009 SHALL have port digit3/digit2/digit1/digit0  output  4 each  nibbles to the 4-digit 7-segment display driver.

Function
REQ-010 SHALL implement FSM states IDLE, OWN_MIN, OWN_FREE, with all outputs registered.
REQ-011 IDLE: if any req bit high, SHALL grant the first requesting index in round-robin order starting at last_owner+1 (mod 3), enter OWN_MIN, clear hold counter; grant/owner valid the next cycle (1-cycle latency).
REQ-012 OWN_MIN: SHALL increment 32-bit hold counter each cycle; at count == HOLD_MIN-1 SHALL enter OWN_FREE; owner is kept even if its req drops.
REQ-013 OWN_FREE: if owner req low and another req high, SHALL switch directly to the next round-robin requester (OWN_MIN, counter cleared) with no IDLE cycle.
REQ-014 OWN_FREE: if owner req low and no other req, SHALL enter IDLE, clear grant, owner = 3.
REQ-015 OWN_FREE: owner req high SHALL keep ownership, counter continuing to increment and saturating at 2^32-1 (subject to REQ-022).
REQ-016 While owned, digit3..digit0 SHALL equal the owner's value from the previous cycle (1-cycle latency), tracking changes every cycle.
REQ-017 In IDLE, digits SHALL hold the last displayed value.
REQ-018 last_owner SHALL update on every grant; round-robin excludes the outgoing owner on a switch unless it is the only requester.
REQ-019 Requests from non-owners SHALL never alter grant during OWN_MIN.

Reset
REQ-020 On rst high at a clock edge, SHALL enter IDLE, grant = 3'b000, owner = 2'd3, digits = 4'h0, counter = 0, last_owner = 2 (req0 first priority), overriding any ownership mid-hold.
REQ-021 First cycle after rst release SHALL behave as IDLE, granting the cycle after req is seen.

Configuration
REQ-022 With DISP_SCHED_TIMEOUT_EN defined, in OWN_FREE with owner req high, another req high and counter >= MAX_HOLD-1, SHALL preempt to the next round-robin requester (OWN_MIN, counter cleared).
REQ-023 Without DISP_SCHED_TIMEOUT_EN, SHALL never preempt a requesting owner; MAX_HOLD is ignored.

Verification (HOLD_MIN=4, MAX_HOLD=10)
REQ-024 Reset, then req=3'b001, value0=16'h1234 -> grant=3'b001 and owner=0 one cycle later; digits 1,2,3,4 one cycle after that.
REQ-025 Owner 0 drops req at cycle 1 of hold while req=3'b010 -> grant remains 3'b001 until 4 hold cycles elapse, then grant=3'b010 with no idle cycle.
REQ-026 req=3'b111 continuously from IDLE after reset, each owner releasing after HOLD_MIN -> grant sequence 001,010,100,001.
REQ-027 Macro defined, owner 1 holds req, req2 high -> preempted to owner 2 at hold count 9; macro undefined -> owner 1 kept indefinitely (run 100 cycles).
REQ-028 rst asserted mid-OWN_MIN -> next cycle grant=000, owner=3, digits=0000; subsequent req=3'b100 granted before any other.
REQ-029 Owner releases with no other req -> IDLE, grant=000, digits keep last value (e.g. ABCD) while value inputs change.

Source files
------------

// File: rtl/display_scheduler.sv
// Round-robin arbiter that hands a 4-digit hex display to one of three requesters, with a minimum hold time.
// Optional owner preemption after MAX_HOLD cycles is enabled with `define DISP_SCHED_TIMEOUT_EN.
module display_scheduler #(
    parameter logic [31:0] HOLD_MIN = 32'd100000000,
    parameter logic [31:0] MAX_HOLD = 32'd500000000
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    output logic [2:0]  grant,
    output logic [1:0]  owner,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_MIN  = 2'd1,
        OWN_FREE = 2'd2
    } state_t;

`ifdef DISP_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  grant_q, grant_d;
    logic [15:0] disp_q, disp_d;

    logic [1:0]  pick;
    logic [2:0]  others;
    logic [15:0] owner_value;
    logic        owner_req;
    logic        timeout_hit;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        rr_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First requester strictly after 'after' in the cyclic order 0,1,2; 3 if none.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] after);
        logic [1:0] a, b, c;
        a = rr_next(after);
        b = rr_next(a);
        c = rr_next(b);
        if (r[a])
            rr_pick = a;
        else if (r[b])
            rr_pick = b;
        else if (r[c])
            rr_pick = c;
        else
            rr_pick = 2'd3;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    always_comb begin
        case (owner_q)
            2'd0:    owner_value = value0;
            2'd1:    owner_value = value1;
            2'd2:    owner_value = value2;
            default: owner_value = disp_q;
        endcase
    end

    assign owner_req   = |(req & grant_q);
    assign others      = req & ~grant_q;
    assign timeout_hit = TIMEOUT_EN && (cnt_q >= MAX_HOLD - 32'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        disp_d  = disp_q;
        pick    = 2'd3;

        case (state_q)
            IDLE: begin
                pick = rr_pick(req, last_q);
            end
            OWN_MIN: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == HOLD_MIN - 32'd1)
                    state_d = OWN_FREE;
            end
            OWN_FREE: begin
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                if (!owner_req) begin
                    if (others != 3'b000) begin
                        pick = rr_pick(others, last_q);
                    end else begin
                        state_d = IDLE;
                        grant_d = 3'b000;
                        owner_d = 2'd3;
                    end
                end else if (timeout_hit && (others != 3'b000)) begin
                    pick = rr_pick(others, last_q);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
                owner_d = 2'd3;
            end
        endcase

        if (pick != 2'd3) begin
            state_d = OWN_MIN;
            cnt_d   = 32'd0;
            owner_d = pick;
            last_d  = pick;
            grant_d = onehot(pick);
        end

        // Digits follow the owner's value one cycle late and freeze while idle.
        if (state_q != IDLE)
            disp_d = owner_value;
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            owner_q <= 2'd3;
            last_q  <= 2'd2;
            grant_q <= 3'b000;
            disp_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            disp_q  <= disp_d;
        end
    end

    assign grant  = grant_q;
    assign owner  = owner_q;
    assign digit3 = disp_q[15:12];
    assign digit2 = disp_q[11:8];
    assign digit1 = disp_q[7:4];
    assign digit0 = disp_q[3:0];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed-vector bench for display_scheduler with HOLD_MIN=4, MAX_HOLD=10.
module tb_display_scheduler;

    logic        clk_100MHz;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] value0, value1, value2;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic [3:0]  digit3, digit2, digit1, digit0;

    int vectors;
    int miscompares;

    display_scheduler #(
        .HOLD_MIN(32'd4),
        .MAX_HOLD(32'd10)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst       (rst),
        .req       (req),
        .value0    (value0),
        .value1    (value1),
        .value2    (value2),
        .grant     (grant),
        .owner     (owner),
        .digit3    (digit3),
        .digit2    (digit2),
        .digit1    (digit1),
        .digit0    (digit0)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        value0 = 16'h1111; value1 = 16'h2222; value2 = 16'h3333;
        do_reset();
        vectors++;
        if (grant !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_grant: got %b required %b", grant, 3'b000);
        end
        vectors++;
        if (owner !== 2'd3) begin
            miscompares++;
            $display("FAIL reset_owner: got %0d required %0d", owner, 3);
        end
        vectors++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_digits: got %h required %h", {digit3, digit2, digit1, digit0}, 16'h0000);
        end
        // first cycle after release stays idle with req low
        tick();
        vectors++;
        if (grant !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b required %b", grant, 3'b000);
        end
    endtask

    task automatic test_grant_and_handoff;
        do_reset();
        value0 = 16'h1234; value1 = 16'h5678;
        req = 3'b001;
        tick();
        vectors++;
        if (grant !== 3'b001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL first_grant: got grant=%b owner=%0d required grant=001 owner=0", grant, owner);
        end
        vectors++;
        if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
            miscompares++;
            $display("FAIL digits_latency: got %h required %h", {digit3, digit2, digit1, digit0}, 16'h0000);
        end
        tick();
        vectors++;
        if (digit3 !== 4'h1 || digit2 !== 4'h2 || digit1 !== 4'h3 || digit0 !== 4'h4) begin
            miscompares++;
            $display("FAIL digits_1234: got %h required %h", {digit3, digit2, digit1, digit0}, 16'h1234);
        end
        // owner 0 drops at hold cycle 1 while requester 1 waits
        req = 3'b010;
        value0 = 16'h4321;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (grant !== 3'b001) begin
                miscompares++;
                $display("FAIL hold_min_kept[%0d]: got %b required %b", i, grant, 3'b001);
            end
            if (i == 0) begin
                vectors++;
                if ({digit3, digit2, digit1, digit0} !== 16'h4321) begin
                    miscompares++;
                    $display("FAIL digits_track: got %h required %h", {digit3, digit2, digit1, digit0}, 16'h4321);
                end
            end
        end
        tick();
        vectors++;
        if (grant !== 3'b010 || owner !== 2'd1) begin
            miscompares++;
            $display("FAIL handoff: got grant=%b owner=%0d required grant=010 owner=1", grant, owner);
        end
        tick();
        vectors++;
        if ({digit3, digit2, digit1, digit0} !== 16'h5678) begin
            miscompares++;
            $display("FAIL digits_new_owner: got %h required %h", {digit3, digit2, digit1, digit0}, 16'h5678);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_seq [4];
        logic [2:0] cur;
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
        do_reset();
        req = 3'b111;
        tick();
        vectors++;
        if (grant !== exp_seq[0]) begin
            miscompares++;
            $display("FAIL rr_step0: got %b required %b", grant, exp_seq[0]);
        end
        for (int s = 1; s < 4; s++) begin
            cur = exp_seq[s-1];
            req = 3'b111 & ~cur;
            repeat (4) tick();
            vectors++;
            if (grant !== cur) begin
                miscompares++;
                $display("FAIL rr_hold%0d: got %b required %b", s, grant, cur);
            end
            tick();
            vectors++;
            if (grant !== exp_seq[s]) begin
                miscompares++;
                $display("FAIL rr_step%0d: got %b required %b", s, grant, exp_seq[s]);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_release_idle;
        do_reset();
        value1 = 16'hABCD;
        req = 3'b010;
        tick();
        req = 3'b000;
        repeat (4) tick();
        vectors++;
        if (grant !== 3'b010) begin
            miscompares++;
            $display("FAIL release_hold: got %b required %b", grant, 3'b010);
        end
        tick();
        vectors++;
        if (grant !== 3'b000 || owner !== 2'd3) begin
            miscompares++;
            $display("FAIL release_idle: got grant=%b owner=%0d required grant=000 owner=3", grant, owner);
        end
        vectors++;
        if ({digit3, digit2, digit1, digit0} !== 16'hABCD) begin
            miscompares++;
            $display("FAIL release_digits: got %h required %h", {digit3, digit2, digit1, digit0}, 16'hABCD);
        end
        value0 = 16'hFFFF; value1 = 16'h0000; value2 = 16'h7777;
        repeat (2) tick();
        vectors++;
        if ({digit3, digit2, digit1, digit0} !== 16'hABCD) begin
            miscompares++;
            $display("FAIL idle_digits_hold: got %h required %h", {digit3, digit2, digit1, digit0}, 16'hABCD);
        end
    endtask

    task automatic test_reset_mid_hold;
        do_reset();
        value0 = 16'h9999; value2 = 16'h2468;
        req = 3'b001;
        repeat (2) tick();
        rst = 1'b1;
        req = 3'b111;
        tick();
        vectors++;
        if (grant !== 3'b000 || owner !== 2'd3 || {digit3, digit2, digit1, digit0} !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid_hold: got grant=%b owner=%0d digits=%h required 000/3/0000",
                     grant, owner, {digit3, digit2, digit1, digit0});
        end
        rst = 1'b0;
        req = 3'b100;
        tick();
        vectors++;
        if (grant !== 3'b100 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL rst_then_req2: got grant=%b owner=%0d required grant=100 owner=2", grant, owner);
        end
        tick();
        vectors++;
        if ({digit3, digit2, digit1, digit0} !== 16'h2468) begin
            miscompares++;
            $display("FAIL rst_then_digits: got %h required %h", {digit3, digit2, digit1, digit0}, 16'h2468);
        end
        req = 3'b000;
    endtask

    task automatic test_timeout;
        int bad;
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b110;
        bad = 0;
`ifdef DISP_SCHED_TIMEOUT_EN
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (grant !== 3'b010) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL timeout_before: got %0d early changes required 0", bad);
        end
        tick();
        vectors++;
        if (grant !== 3'b100 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL timeout_preempt: got grant=%b owner=%0d required grant=100 owner=2", grant, owner);
        end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant !== 3'b010) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL no_preempt: got %0d cycles without owner 1 required 0", bad);
        end
        vectors++;
        if (owner !== 2'd1) begin
            miscompares++;
            $display("FAIL no_preempt_owner: got %0d required %0d", owner, 1);
        end
`endif
        req = 3'b000;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        req = 3'b000;
        value0 = 16'h0; value1 = 16'h0; value2 = 16'h0;
        test_reset();
        test_grant_and_handoff();
        test_round_robin();
        test_release_idle();
        test_reset_mid_hold();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
